// File: rtl/tron_pkg.sv
// tron_pkg: shared types and constants for the light-cycle game datapath.
//   dir_t      - heading encoding (UP=0, DOWN=1, LEFT=2, RIGHT=3)
//   outcome_t  - end-of-game result reported to the display/score logic
//   state_t    - game sequencer states
//   GRID_ROWS  - number of rows (x coordinate range 0..GRID_ROWS-1)
//   GRID_COLS  - number of columns (y coordinate range 0..GRID_COLS-1)
//   is_reverse - true when two headings point in opposite directions
package tron_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    P1_WIN = 2'd1,
    P2_WIN = 2'd2,
    DRAW   = 2'd3
  } outcome_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int GRID_ROWS = 150;
  localparam int GRID_COLS = 200;

  function automatic logic is_reverse(input dir_t a, input dir_t b);
    logic rev;
    rev = 1'b0;
    case (a)
      UP:      rev = (b == DOWN);
      DOWN:    rev = (b == UP);
      LEFT:    rev = (b == RIGHT);
      RIGHT:   rev = (b == LEFT);
      default: rev = 1'b0;
    endcase
    return rev;
  endfunction

endpackage

// File: rtl/player_next_pos.sv
// player_next_pos: purely combinational next-head calculator for one player.
// Ports:
//   x, y  in  10  current head (row, column)
//   dir   in  2   heading to apply (dir_t encoding)
//   nx,ny out 10  candidate head, truncated to 10 bits
//   wall  out 1   candidate leaves the grid on any side
module player_next_pos
  import tron_pkg::*;
(
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [1:0] dir,
  output logic [9:0] nx,
  output logic [9:0] ny,
  output logic       wall
);

  logic [10:0] nx_w;
  logic [10:0] ny_w;

  // One extra bit so that stepping off row/column 0 wraps to 2047, which is
  // caught by the same unsigned upper-bound test as running off the far edge.
  always_comb begin
    nx_w = {1'b0, x};
    ny_w = {1'b0, y};
    case (dir_t'(dir))
      UP:      nx_w = {1'b0, x} - 11'd1;
      DOWN:    nx_w = {1'b0, x} + 11'd1;
      LEFT:    ny_w = {1'b0, y} - 11'd1;
      RIGHT:   ny_w = {1'b0, y} + 11'd1;
      default: ;
    endcase
  end

  assign nx   = nx_w[9:0];
  assign ny   = ny_w[9:0];
  assign wall = (nx_w >= 11'(GRID_ROWS)) || (ny_w >= 11'(GRID_COLS));

endmodule

// File: rtl/player_move.sv
// player_move: holds both players' heads and headings, paces the game from
// the frame tick, presents candidate heads to the trace-update stage and
// either commits the move or ends the game with an outcome.
// Ports:
//   clock, reset                 clock, asynchronous active-high reset
//   start                        begin a game from IDLE or OVER
//   tick                         one-cycle frame strobe
//   p1_dir_req/p1_req_valid      player 1 heading request
//   p2_dir_req/p2_req_valid      player 2 heading request
//   trace_ok                     trace stage accepts the presented candidates
//   new_x1..new_y2               candidate heads (head + pending heading)
//   step                         candidates are being evaluated this cycle
//   commit                       move accepted this cycle
//   x1..y2                       registered heads
//   running                      game in progress
//   outcome                      outcome_t of the last finished game
module player_move
  import tron_pkg::*;
#(
  parameter int MOVE_DIV = 4,
  parameter int P1_X0    = 75,
  parameter int P1_Y0    = 20,
  parameter int P2_X0    = 75,
  parameter int P2_Y0    = 179
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       tick,
  input  logic [1:0] p1_dir_req,
  input  logic       p1_req_valid,
  input  logic [1:0] p2_dir_req,
  input  logic       p2_req_valid,
  input  logic       trace_ok,
  output logic [9:0] new_x1,
  output logic [9:0] new_y1,
  output logic [9:0] new_x2,
  output logic [9:0] new_y2,
  output logic       step,
  output logic       commit,
  output logic [9:0] x1,
  output logic [9:0] y1,
  output logic [9:0] x2,
  output logic [9:0] y2,
  output logic       running,
  output logic [1:0] outcome
);

  localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  state_t           state;
  state_t           state_nxt;
  dir_t             dir1;
  dir_t             dir2;
  dir_t             pend1;
  dir_t             pend2;
  logic [CNT_W-1:0] count;
  outcome_t         outcome_q;
  outcome_t         step_outcome;
  logic             start_game;
  logic             last_tick;
  logic             wall1;
  logic             wall2;
  logic             head_on;
  logic             move_ok;
  dir_t             base1;
  dir_t             base2;
  dir_t             req1;
  dir_t             req2;
  logic             accept1;
  logic             accept2;

  player_next_pos u_next1 (
    .x    (x1),
    .y    (y1),
    .dir  (pend1),
    .nx   (new_x1),
    .ny   (new_y1),
    .wall (wall1)
  );

  player_next_pos u_next2 (
    .x    (x2),
    .y    (y2),
    .dir  (pend2),
    .nx   (new_x2),
    .ny   (new_y2),
    .wall (wall2)
  );

  assign last_tick = (count == CNT_W'(MOVE_DIV - 1));

  // Head-on covers both landing on the same cell and swapping cells.
  assign head_on = ((new_x1 == new_x2) && (new_y1 == new_y2)) ||
                   ((new_x1 == x2) && (new_y1 == y2) &&
                    (new_x2 == x1) && (new_y2 == y1));

  assign move_ok = !wall1 && !wall2 && !head_on && trace_ok;

  always_comb begin
    step_outcome = DRAW;
    if (wall1 && !wall2) begin
      step_outcome = P2_WIN;
    end else if (wall2 && !wall1) begin
      step_outcome = P1_WIN;
    end
  end

  // A request is judged against the heading that will be in force after this
  // edge, so a request landing in a step cycle cannot reverse the new heading.
  assign base1   = step ? pend1 : dir1;
  assign base2   = step ? pend2 : dir2;
  assign req1    = dir_t'(p1_dir_req);
  assign req2    = dir_t'(p2_dir_req);
  assign accept1 = p1_req_valid && (req1 != base1) && !is_reverse(req1, base1);
  assign accept2 = p2_req_valid && (req2 != base2) && !is_reverse(req2, base2);

  // Game sequencer state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_nxt  = state;
    step       = 1'b0;
    commit     = 1'b0;
    start_game = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_game = 1'b1;
          state_nxt  = RUN;
        end
      end
      RUN: begin
        if (tick && last_tick) begin
          step = 1'b1;
          if (move_ok) begin
            commit = 1'b1;
          end else begin
            state_nxt = OVER;
          end
        end
      end
      OVER: begin
        if (start) begin
          start_game = 1'b1;
          state_nxt  = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Heads, headings, tick pacing and outcome.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x1        <= 10'(P1_X0);
      y1        <= 10'(P1_Y0);
      x2        <= 10'(P2_X0);
      y2        <= 10'(P2_Y0);
      dir1      <= RIGHT;
      dir2      <= LEFT;
      pend1     <= RIGHT;
      pend2     <= LEFT;
      count     <= '0;
      outcome_q <= NONE;
    end else if (start_game) begin
      x1        <= 10'(P1_X0);
      y1        <= 10'(P1_Y0);
      x2        <= 10'(P2_X0);
      y2        <= 10'(P2_Y0);
      dir1      <= RIGHT;
      dir2      <= LEFT;
      pend1     <= RIGHT;
      pend2     <= LEFT;
      count     <= '0;
      outcome_q <= NONE;
    end else if (state == RUN) begin
      if (tick) begin
        count <= step ? '0 : count + CNT_W'(1);
      end
      if (step) begin
        dir1 <= pend1;
        dir2 <= pend2;
      end
      if (commit) begin
        x1 <= new_x1;
        y1 <= new_y1;
        x2 <= new_x2;
        y2 <= new_y2;
      end
      if (step && !commit) begin
        outcome_q <= step_outcome;
      end
      if (accept1) begin
        pend1 <= req1;
      end
      if (accept2) begin
        pend2 <= req2;
      end
    end
  end

  assign running = (state == RUN);
  assign outcome = outcome_q;

endmodule

// File: tb/tb_player_move.sv
// tb_player_move: scoreboard bench for player_move. The stimulus process
// drives inputs and advances a behavioural game model; each model step pushes
// the expected candidates, commit and post-step state into a queue that an
// independent monitor pops whenever the DUT raises step.
module tb_player_move;

  localparam int MOVE_DIV = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       tick;
  logic [1:0] p1_dir_req;
  logic       p1_req_valid;
  logic [1:0] p2_dir_req;
  logic       p2_req_valid;
  logic       trace_ok;
  logic [9:0] new_x1, new_y1, new_x2, new_y2;
  logic       step;
  logic       commit;
  logic [9:0] x1, y1, x2, y2;
  logic       running;
  logic [1:0] outcome;

  player_move #(
    .MOVE_DIV (MOVE_DIV),
    .P1_X0    (75),
    .P1_Y0    (20),
    .P2_X0    (75),
    .P2_Y0    (179)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .tick         (tick),
    .p1_dir_req   (p1_dir_req),
    .p1_req_valid (p1_req_valid),
    .p2_dir_req   (p2_dir_req),
    .p2_req_valid (p2_req_valid),
    .trace_ok     (trace_ok),
    .new_x1       (new_x1),
    .new_y1       (new_y1),
    .new_x2       (new_x2),
    .new_y2       (new_y2),
    .step         (step),
    .commit       (commit),
    .x1           (x1),
    .y1           (y1),
    .x2           (x2),
    .y2           (y2),
    .running      (running),
    .outcome      (outcome)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [9:0] nx1, ny1, nx2, ny2;
    logic       cm;
    logic [9:0] ax1, ay1, ax2, ay2;
    logic [1:0] aout;
    logic       arun;
  } exp_t;

  exp_t sb[$];
  int   checks       = 0;
  int   errors       = 0;
  int   commits_seen = 0;

  // Game model: headings 0..3 = up, down, left, right.
  int dx_tab[4]  = '{-1, 1, 0, 0};
  int dy_tab[4]  = '{0, 0, -1, 1};
  int opp_tab[4] = '{1, 0, 3, 2};
  bit m_run;
  int m_x[2], m_y[2], m_dir[2], m_pend[2];
  int m_ticks;
  int m_out;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_new_game();
    m_x     = '{75, 75};
    m_y     = '{20, 179};
    m_dir   = '{3, 2};
    m_pend  = '{3, 2};
    m_ticks = 0;
    m_out   = 0;
  endfunction

  function automatic void model_request(input int p, input int d);
    if (d != m_dir[p] && d != opp_tab[m_dir[p]]) m_pend[p] = d;
  endfunction

  function automatic void model_step(input bit tok);
    int   cx[2], cy[2];
    bit   w[2];
    bit   hon, ok;
    exp_t e;
    for (int p = 0; p < 2; p++) begin
      cx[p] = m_x[p] + dx_tab[m_pend[p]];
      cy[p] = m_y[p] + dy_tab[m_pend[p]];
      w[p]  = (cx[p] < 0) || (cx[p] >= 150) || (cy[p] < 0) || (cy[p] >= 200);
    end
    hon = (cx[0] == cx[1] && cy[0] == cy[1]) ||
          (cx[0] == m_x[1] && cy[0] == m_y[1] && cx[1] == m_x[0] && cy[1] == m_y[0]);
    ok = !w[0] && !w[1] && !hon && tok;
    e.nx1 = 10'(cx[0]);
    e.ny1 = 10'(cy[0]);
    e.nx2 = 10'(cx[1]);
    e.ny2 = 10'(cy[1]);
    if (ok) begin
      m_x = cx;
      m_y = cy;
    end else begin
      m_run = 0;
      if (w[0] && !w[1])      m_out = 2;
      else if (w[1] && !w[0]) m_out = 1;
      else                    m_out = 3;
    end
    m_dir = m_pend;
    e.cm   = ok;
    e.ax1  = 10'(m_x[0]);
    e.ay1  = 10'(m_y[0]);
    e.ax2  = 10'(m_x[1]);
    e.ay2  = 10'(m_y[1]);
    e.aout = 2'(m_out);
    e.arun = m_run;
    sb.push_back(e);
  endfunction

  // Drives one clock cycle of inputs (called at posedge+1) and advances the model.
  task automatic apply_stimulus(input bit tk, input bit st, input bit v1, input int d1,
                                input bit v2, input int d2, input bit tok);
    tick         = tk;
    start        = st;
    p1_req_valid = v1;
    p1_dir_req   = 2'(d1);
    p2_req_valid = v2;
    p2_dir_req   = 2'(d2);
    trace_ok     = tok;
    if (!m_run) begin
      if (st) begin
        model_new_game();
        m_run = 1;
      end
    end else begin
      if (tk) begin
        if (m_ticks == MOVE_DIV - 1) begin
          m_ticks = 0;
          model_step(tok);
        end else begin
          m_ticks++;
        end
      end
      if (v1) model_request(0, d1);
      if (v2) model_request(1, d2);
    end
    @(posedge clock);
    #1;
    check_output("running", running, m_run);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic tick_cycles(input int n, input bit tok);
    for (int i = 0; i < n; i++) apply_stimulus(1, 0, 0, 0, 0, 0, tok);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick  = 1'b0;
    start = 1'b0;
    model_new_game();
    m_run = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_drained(input string name);
    idle_cycles(2);
    check_output(name, sb.size(), 0);
    sb.delete();
  endtask

  task automatic play_until_over(input int limit, input bit tok);
    for (int i = 0; i < limit && m_run; i++) apply_stimulus(1, 0, 0, 0, 0, 0, tok);
    check_output("game_ended_in_budget", m_run, 0);
  endtask

  task automatic check_start_state(input string tag);
    check_output({tag, "_x1"}, x1, 75);
    check_output({tag, "_y1"}, y1, 20);
    check_output({tag, "_x2"}, x2, 75);
    check_output({tag, "_y2"}, y2, 179);
    check_output({tag, "_outcome"}, outcome, 0);
  endtask

  // Monitor: every DUT step is matched against the oldest expected step.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (step !== 1'b1 && commit === 1'b1) check_output("stray_commit", 1, 0);
      if (step === 1'b1) begin
        if (sb.size() == 0) begin
          check_output("unexpected_step", 1, 0);
        end else begin
          e = sb.pop_front();
          check_output("new_x1", new_x1, e.nx1);
          check_output("new_y1", new_y1, e.ny1);
          check_output("new_x2", new_x2, e.nx2);
          check_output("new_y2", new_y2, e.ny2);
          check_output("commit", commit, e.cm);
          if (commit === 1'b1) commits_seen++;
          @(posedge clock);
          #1;
          check_output("post_x1", x1, e.ax1);
          check_output("post_y1", y1, e.ay1);
          check_output("post_x2", x2, e.ax2);
          check_output("post_y2", y2, e.ay2);
          check_output("post_outcome", outcome, e.aout);
          check_output("post_running", running, e.arun);
        end
      end
    end
  end

  initial begin
    int c0;
    reset        = 1'b1;
    start        = 1'b0;
    tick         = 1'b0;
    p1_dir_req   = 2'd0;
    p1_req_valid = 1'b0;
    p2_dir_req   = 2'd0;
    p2_req_valid = 1'b0;
    trace_ok     = 1'b1;
    model_new_game();
    m_run = 0;
    #2;
    check_start_state("reset");
    check_output("reset_running", running, 0);
    check_output("reset_step", step, 0);
    check_output("reset_commit", commit, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    $display("[TB] test 1: two steps over eight ticks");
    apply_stimulus(0, 1, 0, 0, 0, 0, 1);
    c0 = commits_seen;
    tick_cycles(8, 1);
    check_output("t1_commits", commits_seen - c0, 2);
    check_output("t1_x1", x1, 75);
    check_output("t1_y1", y1, 22);
    check_output("t1_x2", x2, 75);
    check_output("t1_y2", y2, 177);

    $display("[TB] test 2: reverse request ignored, later request wins");
    apply_stimulus(0, 0, 1, 2, 0, 0, 1);
    apply_stimulus(0, 0, 1, 1, 0, 0, 1);
    tick_cycles(4, 1);
    check_output("t2_x1", x1, 76);
    check_output("t2_y1", y1, 22);
    check_output("t2_heading_down", new_x1, 77);
    check_drained("t2_drained");

    $display("[TB] test 3: P1 runs off the top edge");
    do_reset();
    apply_stimulus(0, 1, 0, 0, 0, 0, 1);
    apply_stimulus(0, 0, 1, 0, 0, 0, 1);
    play_until_over(400, 1);
    check_output("t3_outcome", outcome, 2);
    check_output("t3_x1", x1, 0);
    check_output("t3_y1", y1, 20);
    check_drained("t3_drained");

    $display("[TB] test 4: head-on swap");
    do_reset();
    apply_stimulus(0, 1, 0, 0, 0, 0, 1);
    play_until_over(400, 1);
    check_output("t4_outcome", outcome, 3);
    check_output("t4_y1", y1, 99);
    check_output("t4_y2", y2, 100);
    check_drained("t4_drained");

    $display("[TB] test 5: trace refusal then restart");
    do_reset();
    apply_stimulus(0, 1, 0, 0, 0, 0, 1);
    tick_cycles(4, 1);
    tick_cycles(4, 0);
    check_output("t5_outcome", outcome, 3);
    check_output("t5_y1", y1, 21);
    tick_cycles(3, 1);
    apply_stimulus(0, 1, 0, 0, 0, 0, 1);
    check_start_state("t5_restart");
    tick_cycles(4, 1);
    check_output("t5_y1_after", y1, 21);
    check_drained("t5_drained");

    $display("[TB] test 6: reset during a step");
    do_reset();
    apply_stimulus(0, 1, 0, 0, 0, 0, 1);
    tick_cycles(7, 1);
    tick     = 1'b1;
    trace_ok = 1'b1;
    #1;
    check_output("t6_step_before", step, 1);
    reset = 1'b1;
    #1;
    check_output("t6_step", step, 0);
    check_output("t6_commit", commit, 0);
    check_output("t6_running", running, 0);
    check_start_state("t6");
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick  = 1'b0;
    model_new_game();
    m_run = 0;
    check_drained("t6_drained");

    $display("[TB] random games");
    for (int g = 0; g < 6; g++) begin
      do_reset();
      apply_stimulus(0, 1, 0, 0, 0, 0, 1);
      for (int c = 0; c < 400; c++) begin
        bit tk, st, v1, v2, tok;
        tk  = ($urandom_range(0, 9) < 6);
        st  = ($urandom_range(0, 49) == 0);
        v1  = !tk && ($urandom_range(0, 4) == 0);
        v2  = !tk && ($urandom_range(0, 4) == 0);
        tok = ($urandom_range(0, 19) != 0);
        apply_stimulus(tk, st, v1, int'($urandom_range(0, 3)), v2, int'($urandom_range(0, 3)), tok);
      end
      check_drained("rand_drained");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
